// File: rtl/quickQ_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quickQ_pkg                                                                  |
// | Shared sequencer state encoding and count-width helper for QuickQ.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package quickQ_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENQ_WALK  = 3'd1,
    S_ENQ_TAIL  = 3'd2,
    S_DEQ_HEAD  = 3'd3,
    S_DEQ_SHIFT = 3'd4
  } qsState_t;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int QS_CW(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/quickq_cmp_swap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quickq_cmp_swap                                                             |
// | Insertion compare: the carried value displaces the stored one if smaller.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module quickq_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] carry_i,
  input  logic [W-1:0] rdata_i,
  output logic         swap_o,
  output logic [W-1:0] wdata_o,
  output logic [W-1:0] next_carry_o
);

  // Strict compare keeps a new key behind existing equal keys.
  assign swap_o       = (carry_i < rdata_i);
  assign wdata_o      = carry_i;
  assign next_carry_o = swap_o ? rdata_i : carry_i;

endmodule
`default_nettype wire

// File: rtl/quickq_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quickq_seq_ctrl                                                             |
// | Sorted-array priority queue sequencer driving an external 1R1W BRAM.        |
// | Optional QUICKQ_STATS_EN adds enq/deq/err event counters.                   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module quickq_seq_ctrl
  import quickQ_pkg::*;
#(
  parameter int  W  = 8,
  parameter int  D  = 128,
  localparam int CW = QS_CW(D),
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic [W-1:0]  data_i,
  output logic          ready_o,
  output logic [W-1:0]  data_o,
  output logic          data_valid_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          err_o,
`ifdef QUICKQ_STATS_EN
  output logic [31:0]   stat_enq_o,
  output logic [31:0]   stat_deq_o,
  output logic [31:0]   stat_err_o,
`endif
  output logic [AW-1:0] bram_raddr_o,
  input  logic [W-1:0]  bram_rdata_i,
  output logic          bram_we_o,
  output logic [AW-1:0] bram_waddr_o,
  output logic [W-1:0]  bram_wdata_o
);

  qsState_t      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [W-1:0]  carry_q, carry_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          data_valid_q, data_valid_d;
  logic          err_q, err_d;
  logic          we_q, we_d;

  logic          w_idle, w_full, w_empty;
  logic          w_deq_acc, w_enq_acc, w_err;
  logic [CW-1:0] w_idx_ext;
  logic          w_last_walk, w_last_shift;
  logic          w_swap;
  logic [W-1:0]  w_cs_wdata, w_next_carry;

  assign w_idle    = (state_q == S_IDLE);
  assign w_full    = (count_q == CW'(D));
  assign w_empty   = (count_q == '0);
  assign w_deq_acc = w_idle && deq_i && !w_empty;
  assign w_enq_acc = w_idle && !deq_i && enq_i && !w_full;
  assign w_err     = w_idle && (deq_i ? w_empty : (enq_i && w_full));

  assign w_idx_ext    = CW'(idx_q);
  assign w_last_walk  = (w_idx_ext == count_q - CW'(1));
  assign w_last_shift = (w_idx_ext == count_q - CW'(2));

  quickq_cmp_swap #(
    .W (W)
  ) u_cmp_swap (
    .carry_i      (carry_q),
    .rdata_i      (bram_rdata_i),
    .swap_o       (w_swap),
    .wdata_o      (w_cs_wdata),
    .next_carry_o (w_next_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      carry_q      <= '0;
      data_q       <= '0;
      wdata_q      <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      carry_q      <= carry_d;
      data_q       <= data_d;
      wdata_q      <= wdata_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      we_q         <= we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    carry_d      = carry_q;
    data_d       = data_q;
    wdata_d      = wdata_q;
    data_valid_d = 1'b0;
    err_d        = w_err;
    we_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_deq_acc) begin
          raddr_d = '0;
          state_d = S_DEQ_HEAD;
        end else if (w_enq_acc) begin
          carry_d = data_i;
          idx_d   = '0;
          raddr_d = '0;
          state_d = w_empty ? S_ENQ_TAIL : S_ENQ_WALK;
        end
      end

      // rdata here is mem[idx]; a smaller carry claims the slot and pushes the old key right.
      S_ENQ_WALK: begin
        if (w_swap) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = w_cs_wdata;
        end
        carry_d = w_next_carry;
        raddr_d = idx_q + AW'(1);
        idx_d   = idx_q + AW'(1);
        if (w_last_walk) state_d = S_ENQ_TAIL;
      end

      S_ENQ_TAIL: begin
        we_d    = 1'b1;
        waddr_d = AW'(count_q);
        wdata_d = carry_q;
        count_d = count_q + CW'(1);
        state_d = S_IDLE;
      end

      S_DEQ_HEAD: begin
        data_d       = bram_rdata_i;
        data_valid_d = 1'b1;
        idx_d        = '0;
        raddr_d      = AW'(1);
        if (count_q == CW'(1)) begin
          count_d = count_q - CW'(1);
          state_d = S_IDLE;
        end else begin
          state_d = S_DEQ_SHIFT;
        end
      end

      // rdata here is mem[idx+1]; copy it down one slot.
      S_DEQ_SHIFT: begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = bram_rdata_i;
        raddr_d = idx_q + AW'(2);
        idx_d   = idx_q + AW'(1);
        if (w_last_shift) begin
          count_d = count_q - CW'(1);
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef QUICKQ_STATS_EN
  logic [31:0] stat_enq_q, stat_deq_q, stat_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq_q <= '0;
      stat_deq_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (w_enq_acc) stat_enq_q <= stat_enq_q + 32'd1;
      if (w_deq_acc) stat_deq_q <= stat_deq_q + 32'd1;
      if (w_err)     stat_err_q <= stat_err_q + 32'd1;
    end
  end

  assign stat_enq_o = stat_enq_q;
  assign stat_deq_o = stat_deq_q;
  assign stat_err_o = stat_err_q;
`endif

  assign ready_o      = w_idle;
  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign count_o      = count_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign err_o        = err_q;
  assign bram_raddr_o = raddr_q;
  assign bram_we_o    = we_q;
  assign bram_waddr_o = waddr_q;
  assign bram_wdata_o = wdata_q;

endmodule
`default_nettype wire
